// File: rtl/inst_mem_resp.sv
// Instruction-memory responder: fixed-latency word fetch with a stall request
// towards the fetch stage, plus a program-load write port into the same array.
module inst_mem_resp #(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH_LOG2  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce,
  input  logic [31:0] addr,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        addr_err,
  output logic        stall,
  input  logic        prog_we,
  input  logic [31:0] prog_addr,
  input  logic [31:0] prog_data
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Word-aligned and inside the array; anything else is answered with a NOP.
  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> (DEPTH_LOG2 + 2)) != 32'd0);
  endfunction

  logic [31:0]      mem [DEPTH];
  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      inst_q, inst_d;
  logic             inst_valid_q, inst_valid_d;
  logic             addr_err_q, addr_err_d;
  logic             stall_q, stall_d;
  logic             resp_s;
  logic [31:0]      rd_addr_s;
  logic [31:0]      rd_data_s;
  logic             prog_ok_s;
  logic             unused_prog_lsb_s;

  // With no wait states the read happens on the accepting edge, before addr_q holds it.
  assign rd_addr_s         = (state_q == S_WAIT) ? addr_q : addr;
  assign rd_data_s         = mem[rd_addr_s[DEPTH_LOG2+1:2]];
  assign prog_ok_s         = ((prog_addr >> (DEPTH_LOG2 + 2)) == 32'd0);
  assign unused_prog_lsb_s = ^prog_addr[1:0];

  // Next-state and next-output computation for the fetch FSM.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    addr_d       = addr_q;
    inst_d       = inst_q;
    inst_valid_d = 1'b0;
    addr_err_d   = 1'b0;
    stall_d      = 1'b0;
    resp_s       = 1'b0;
    case (state_q)
      S_IDLE, S_RESP: begin
        if (ce) begin
          addr_d = addr;
          if (WAIT_CYCLES > 0) begin
            state_d    = S_WAIT;
            wait_cnt_d = CNT_LOAD;
            stall_d    = 1'b1;
          end else begin
            state_d = S_RESP;
            resp_s  = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!ce) begin
          state_d = S_IDLE;
        end else if (wait_cnt_q != '0) begin
          wait_cnt_d = wait_cnt_q - CNT_W'(1);
          stall_d    = 1'b1;
        end else begin
          state_d = S_RESP;
          resp_s  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Array read is sampled before this edge's program write lands: read-before-write.
    if (resp_s) begin
      inst_valid_d = 1'b1;
      if (addr_bad(rd_addr_s)) begin
        inst_d     = 32'h0000_0000;
        addr_err_d = 1'b1;
      end else begin
        inst_d     = rd_data_s;
        addr_err_d = 1'b0;
      end
    end else begin
      inst_valid_d = 1'b0;
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wait_cnt_q   <= '0;
      addr_q       <= 32'h0000_0000;
      inst_q       <= 32'h0000_0000;
      inst_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
      stall_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      addr_q       <= addr_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      addr_err_q   <= addr_err_d;
      stall_q      <= stall_d;
    end
  end

  // Program-load port; storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (prog_we && prog_ok_s) begin
      mem[prog_addr[DEPTH_LOG2+1:2]] <= prog_data;
    end
  end

  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign addr_err   = addr_err_q;
  assign stall      = stall_q;

endmodule

// File: doc/inst_mem_resp.md
# inst_mem_resp

Instruction-memory responder at the far end of the fetch interface: accepts the fetch address and chip-enable from the program-counter stage and returns the addressed 32-bit instruction word after a fixed, parameterised number of wait states. It drives a stall request back to the fetch stage while a read is outstanding. It also exposes a word-write port so the memory can be loaded with a program before or during fetch. Reads use word addressing and flag misaligned or out-of-range accesses.

## Interface
- WAIT_CYCLES, 2, wait states between request acceptance and response (0 allowed)
- DEPTH_LOG2, 10, log2 of memory depth in 32-bit words
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ce  in  1  fetch chip-enable from PC stage; 1 = request valid
- addr  in  32  byte address of instruction to fetch
- inst  out  32  instruction word; valid when inst_valid=1
- inst_valid  out  1  one-cycle response strobe
- addr_err  out  1  qualifies inst_valid: misaligned or out-of-range access
- stall  out  1  1 = request outstanding, fetch stage must hold addr
- prog_we  in  1  program-load write enable
- prog_addr  in  32  program-load byte address (bits [1:0] ignored)
- prog_data  in  32  program-load data

## Operation
- Storage: 2^DEPTH_LOG2 x 32-bit array, not reset. Word index = addr[DEPTH_LOG2+1:2].
- Reset: state IDLE, wait_cnt 0, inst 32'h0, inst_valid 0, addr_err 0, stall 0, addr_q 0.
- FSM states IDLE, WAIT, RESP.
  - IDLE: ce=1 -> capture addr into addr_q; go WAIT (wait_cnt=WAIT_CYCLES-1) if WAIT_CYCLES>0, else RESP. ce=0 -> stay.
  - WAIT: ce=0 -> abort to IDLE, no response. wait_cnt≠0 -> decrement. wait_cnt=0 -> RESP.
  - RESP: inst_valid=1 for this cycle. ce=1 -> capture new addr (back-to-back), same transition as from IDLE. ce=0 -> IDLE.
- inst/addr_err are registered on the edge entering RESP, from addr_q.
- Error: addr_q[1:0]≠0 or addr_q[31:DEPTH_LOG2+2]≠0 -> inst=32'h0 (NOP), addr_err=1. Otherwise inst=mem[index], addr_err=0.
- inst holds its value outside RESP; inst_valid and addr_err are 0 outside RESP.
- stall = 1 exactly in WAIT; 0 in IDLE and RESP. WAIT_CYCLES=0 -> stall never asserts.
- Program port: prog_we=1 writes prog_data to mem[prog_addr[DEPTH_LOG2+1:2]] on the rising edge, in any state; out-of-range prog_addr (upper bits nonzero) discarded.
- Simultaneous write and response read of same word on same edge: response returns old data (read-before-write).
- Reset mid-operation: immediate return to reset values; pending request discarded; memory contents unchanged.

## Timing
- Request accepted at edge E (ce=1 in IDLE or RESP).
- Cycles E+1 .. E+WAIT_CYCLES: WAIT, stall=1.
- Cycle E+WAIT_CYCLES+1: RESP, inst_valid=1, inst valid. Latency = WAIT_CYCLES+1 cycles.
- Sustained throughput with ce held high: one word per WAIT_CYCLES+1 cycles; with WAIT_CYCLES=0, one word per cycle.
- addr must remain stable while stall=1; addr changes during WAIT are ignored (addr_q used).
- Memory read occurs on the edge leaving the final WAIT cycle (or the accepting edge when WAIT_CYCLES=0).
- prog write visible to a read whose read edge is strictly later than the write edge.

## Test plan
- Reset: rst_n=0 mid-WAIT -> inst=0, inst_valid=0, stall=0, addr_err=0 asynchronously; state IDLE after release.
- Load + fetch (WAIT_CYCLES=2, DEPTH_LOG2=4): write mem[1]=32'h2401_0005, ce=1 addr=4 at edge E -> stall=1 in E+1,E+2; E+3 inst=32'h2401_0005, inst_valid=1, addr_err=0.
- Back-to-back (WAIT_CYCLES=0): ce held 1, addr 0,4,8 on consecutive edges with mem[0..2]=A,B,C -> inst A,B,C on consecutive cycles, inst_valid continuously 1, stall always 0.
- Errors (DEPTH_LOG2=4): addr=32'h6 -> inst=0, addr_err=1; addr=32'h40 -> inst=0, addr_err=1; both with inst_valid=1 for one cycle.
- Abort: ce=1 addr=8 then ce=0 during first WAIT cycle -> IDLE next cycle, no inst_valid, stall=0.
- Write collision (WAIT_CYCLES=1): mem[3]=32'h1111_1111; fetch addr=12; prog_we to addr 12 with 32'h2222_2222 on the read edge -> inst=32'h1111_1111; re-fetch -> 32'h2222_2222.
